conv_seq_ctrl: RTL and testbench

- Control sequencer for the 1-D convolution datapath (x buffer, filter ROM, MAC, output register).
- Loads one frame of N input samples through the s_ handshake.
- Then sequences N-M+1 dot products of length M: drives buffer/ROM read addresses and the MAC strobes, and presents each result on the m_ handshake.
- Carries no data; addresses and strobes only.

---
 rtl/conv_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_conv_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: control sequencer for the 1-D convolution datapath.
// Loads one frame of N samples into the x buffer. It then issues N-M+1 dot
// products of length M by driving the x-buffer and filter-ROM read addresses
// and the MAC strobes. Each result is presented on the y handshake. The block
// carries no sample data.
//
// Optional build feature: define CONV_SEQ_CTRL_PERF_EN to add the stall_cnt
// and frame_cnt performance counters. Sequencing is the same in both builds.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   s_valid_x / s_ready_x upstream sample handshake (ready only in LOAD)
//   wr_en_x               x-buffer write strobe (accepted sample)
//   addr_x                x-buffer write address (LOAD) / read address
//   addr_f                filter ROM read address
//   clear_acc, en_acc     MAC strobes, one cycle behind the issued read
//   m_valid_y / m_ready_y result handshake
//   stall_cnt, frame_cnt  (PERF_EN only) OUT stall cycles, finished frames
module conv_seq_ctrl #(
  parameter int unsigned N    = 128,
  parameter int unsigned M    = 32,
  parameter int unsigned AW_X = $clog2(N),
  parameter int unsigned AW_F = $clog2(M)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid_x,
  output logic            s_ready_x,
  output logic            wr_en_x,
  output logic [AW_X-1:0] addr_x,
  output logic [AW_F-1:0] addr_f,
  output logic            clear_acc,
  output logic            en_acc,
  output logic            m_valid_y,
  input  logic            m_ready_y
`ifdef CONV_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [15:0]     frame_cnt
`endif
);

  localparam logic [AW_X-1:0] LAST_WR   = AW_X'(N - 1);
  localparam logic [AW_X-1:0] LAST_BASE = AW_X'(N - M);
  localparam logic [AW_F-1:0] LAST_K    = AW_F'(M - 1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [AW_X-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW_X-1:0] base_q, base_d;
  logic [AW_F-1:0] k_q, k_d;
  logic            issue_c;

  // Ready is decoded from state. It is gated by reset so that no sample is
  // accepted while the block is held in reset.
  assign s_ready_x = (state_q == LOAD) & ~reset;
  assign wr_en_x   = s_valid_x & s_ready_x;

  // k stops at M-1 rather than wrapping. Because of this, addresses stay
  // frozen at the last tap through DRAIN and OUT.
  assign addr_x = (state_q == LOAD) ? wr_cnt_q : (base_q + AW_X'(k_q));
  assign addr_f = k_q;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LOAD;
      wr_cnt_q  <= '0;
      base_q    <= '0;
      k_q       <= '0;
      en_acc    <= 1'b0;
      clear_acc <= 1'b0;
      m_valid_y <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      base_q    <= base_d;
      k_q       <= k_d;
      en_acc    <= issue_c;
      clear_acc <= issue_c & (k_q == '0);
      m_valid_y <= (state_d == OUT);
    end
  end

  // Next-state and issue logic
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    base_d   = base_q;
    k_d      = k_q;
    issue_c  = 1'b0;
    case (state_q)
      LOAD: begin
        if (wr_en_x) begin
          if (wr_cnt_q == LAST_WR) begin
            wr_cnt_d = '0;
            base_d   = '0;
            k_d      = '0;
            state_d  = COMPUTE;
          end else begin
            wr_cnt_d = wr_cnt_q + AW_X'(1);
          end
        end
      end
      COMPUTE: begin
        issue_c = 1'b1;
        if (k_q == LAST_K) begin
          state_d = DRAIN;
        end else begin
          k_d = k_q + AW_F'(1);
        end
      end
      DRAIN: begin
        state_d = OUT;
      end
      OUT: begin
        if (m_ready_y) begin
          k_d = '0;
          if (base_q == LAST_BASE) begin
            wr_cnt_d = '0;
            base_d   = '0;
            state_d  = LOAD;
          end else begin
            base_d  = base_q + AW_X'(1);
            state_d = COMPUTE;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

`ifdef CONV_SEQ_CTRL_PERF_EN
  // Performance counters: saturating OUT-stall cycles, wrapping frame count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      frame_cnt <= '0;
    end else begin
      if ((state_q == OUT) && !m_ready_y && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if ((state_q == OUT) && m_ready_y && (base_q == LAST_BASE)) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench for conv_seq_ctrl.
// Two instances are used: the default 128/32 configuration with directed
// stimulus, and a small 8/3 configuration with random handshakes. Stimulus
// pushes the expected window base of every y into a per-instance queue. A
// negedge monitor rebuilds each dot-product window from the MAC strobes and
// the issued addresses, then pops and compares on every y handshake.
`timescale 1ns/1ps
module tb_conv_seq_ctrl;

  localparam int N0 = 128;
  localparam int M0 = 32;
  localparam int N1 = 8;
  localparam int M1 = 3;
  localparam int AX0 = $clog2(N0);
  localparam int AF0 = $clog2(M0);
  localparam int AX1 = $clog2(N1);
  localparam int AF1 = $clog2(M1);
  localparam int NN [2] = '{N0, N1};
  localparam int MM [2] = '{M0, M1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, s_valid_x, s_ready_x, wr_en_x, clear_acc, en_acc, m_valid_y, m_ready_y;
  logic [AX0-1:0] addr_x;
  logic [AF0-1:0] addr_f;
  logic           reset_s, s_valid_s, s_ready_s, wr_en_s, clear_s, en_s, m_valid_s, m_ready_s;
  logic [AX1-1:0] addr_x_s;
  logic [AF1-1:0] addr_f_s;
`ifdef CONV_SEQ_CTRL_PERF_EN
  logic [31:0] stall_cnt, stall_cnt_s;
  logic [15:0] frame_cnt, frame_cnt_s;
`endif

  conv_seq_ctrl #(.N(N0), .M(M0)) dut (
    .clk(clk), .reset(reset), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .wr_en_x(wr_en_x), .addr_x(addr_x), .addr_f(addr_f), .clear_acc(clear_acc),
    .en_acc(en_acc), .m_valid_y(m_valid_y), .m_ready_y(m_ready_y)
`ifdef CONV_SEQ_CTRL_PERF_EN
    , .stall_cnt(stall_cnt), .frame_cnt(frame_cnt)
`endif
  );

  conv_seq_ctrl #(.N(N1), .M(M1)) dut_s (
    .clk(clk), .reset(reset_s), .s_valid_x(s_valid_s), .s_ready_x(s_ready_s),
    .wr_en_x(wr_en_s), .addr_x(addr_x_s), .addr_f(addr_f_s), .clear_acc(clear_s),
    .en_acc(en_s), .m_valid_y(m_valid_s), .m_ready_y(m_ready_s)
`ifdef CONV_SEQ_CTRL_PERF_EN
    , .stall_cnt(stall_cnt_s), .frame_cnt(frame_cnt_s)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Scoreboard queues: expected window base of each y, in order
  int bq0[$];
  int bq1[$];

  // Monitor view of both instances
  logic [31:0] ax [2];
  logic [31:0] af [2];
  logic wre [2], ena [2], clr [2], mv [2], rdy [2], rs [2];
  always_comb begin
    ax[0] = 32'(addr_x);   ax[1] = 32'(addr_x_s);
    af[0] = 32'(addr_f);   af[1] = 32'(addr_f_s);
    wre[0] = wr_en_x;      wre[1] = wr_en_s;
    ena[0] = en_acc;       ena[1] = en_s;
    clr[0] = clear_acc;    clr[1] = clear_s;
    mv[0] = m_valid_y;     mv[1] = m_valid_s;
    rdy[0] = m_ready_y;    rdy[1] = m_ready_s;
    rs[0] = reset;         rs[1] = reset_s;
  end

  int cyc = 0;
  int wexp [2] = '{0, 0};
  int wcnt [2] = '{0, 0};
  int ycnt [2] = '{0, 0};
  int taps [2] = '{0, 0};
  int clr_cyc [2] = '{0, 0};
  logic [31:0] first_x [2];
  logic [31:0] pax [2];
  logic [31:0] paf [2];
  logic pmv [2];

  always @(negedge clk) begin : mon
    int qs, eb;
    string p;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "big" : "small";
      if (rs[i]) begin
        wexp[i] = 0; taps[i] = 0; clr_cyc[i] = 0; first_x[i] = '0; pmv[i] = 1'b0;
      end else begin
        if (wre[i]) begin
          check({p, "_wr_addr"}, ax[i], 32'(wexp[i]));
          wexp[i] = (wexp[i] + 1) % NN[i];
          wcnt[i]++;
        end
        if (clr[i]) check({p, "_clear_with_en"}, 32'(ena[i]), 32'd1);
        if (ena[i]) begin
          if (clr[i]) begin
            first_x[i] = pax[i]; taps[i] = 0; clr_cyc[i] = cyc;
          end
          check({p, "_tap_addr_x"}, pax[i], first_x[i] + 32'(taps[i]));
          check({p, "_tap_addr_f"}, paf[i], 32'(taps[i]));
          taps[i]++;
        end
        if (mv[i]) check({p, "_en_acc_in_out"}, 32'(ena[i]), 32'd0);
        if (mv[i] && !pmv[i]) begin
          check({p, "_latency"}, 32'(cyc - clr_cyc[i]), 32'(MM[i]));
          check({p, "_tap_count"}, 32'(taps[i]), 32'(MM[i]));
        end
        if (mv[i] && pmv[i]) begin
          check({p, "_hold_addr_x"}, ax[i], pax[i]);
          check({p, "_hold_addr_f"}, af[i], paf[i]);
        end
        if (mv[i] && rdy[i]) begin
          qs = (i == 0) ? bq0.size() : bq1.size();
          check({p, "_y_pending"}, 32'(qs > 0), 32'd1);
          if (qs > 0) begin
            if (i == 0) eb = bq0.pop_front();
            else        eb = bq1.pop_front();
            check({p, "_y_base"}, first_x[i], 32'(eb));
          end
          ycnt[i]++;
        end
        pmv[i] = mv[i];
      end
      pax[i] = ax[i];
      paf[i] = af[i];
    end
  end

  task automatic check_reset_big();
    check("rst_s_ready", 32'(s_ready_x), 32'd0);
    check("rst_wr_en", 32'(wr_en_x), 32'd0);
    check("rst_addr_x", 32'(addr_x), 32'd0);
    check("rst_addr_f", 32'(addr_f), 32'd0);
    check("rst_en_acc", 32'(en_acc), 32'd0);
    check("rst_clear_acc", 32'(clear_acc), 32'd0);
    check("rst_m_valid", 32'(m_valid_y), 32'd0);
  endtask

  task automatic load_frame_big();
    for (int b = 0; b <= N0 - M0; b++) bq0.push_back(b);
    s_valid_x = 1'b1;
    repeat (N0) @(posedge clk);
    #1;
    s_valid_x = 1'b0;
  endtask

  task automatic wait_y(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (ycnt[i] < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("y_count_%0d", target), 32'(ycnt[i]), 32'(target));
  endtask

  initial begin : stim
    int n;
    reset = 1'b1; s_valid_x = 1'b0; m_ready_y = 1'b0;
    reset_s = 1'b1; s_valid_s = 1'b0; m_ready_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_big();
    check("small_rst_s_ready", 32'(s_ready_s), 32'd0);
    reset = 1'b0;
    #1;
    check("s_ready_after_reset", 32'(s_ready_x), 32'd1);

    // Frame 1: full-rate load, then a 10-cycle stall on the third output
    m_ready_y = 1'b1;
    load_frame_big();
    check("s_ready_after_load", 32'(s_ready_x), 32'd0);
    check("writes_frame1", 32'(wcnt[0]), 32'(N0));
    wait_y(0, 2, 200);
    m_ready_y = 1'b0;
    n = 0;
    while (!m_valid_y && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stall_reached_out", 32'(m_valid_y), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    check("stall_valid_held", 32'(m_valid_y), 32'd1);
`ifdef CONV_SEQ_CTRL_PERF_EN
    check("stall_cnt", stall_cnt, 32'd10);
`endif
    m_ready_y = 1'b1;
    wait_y(0, 97, 97 * 40);
    check("load_after_frame", 32'(s_ready_x), 32'd1);
    check("wr_cnt_after_frame", 32'(addr_x), 32'd0);
    check("queue_empty_frame1", 32'(bq0.size()), 32'd0);
`ifdef CONV_SEQ_CTRL_PERF_EN
    check("frame_cnt_1", 32'(frame_cnt), 32'd1);
`endif

    // Frame 2: abort with reset at k=15 of output 40
    load_frame_big();
    wait_y(0, 97 + 39, 40 * 40);
    repeat (15) @(posedge clk);
    #1;
    check("abort_addr_f_k15", 32'(addr_f), 32'd15);
    reset = 1'b1;
    #1;
    check_reset_big();
    bq0.delete();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("s_ready_after_abort", 32'(s_ready_x), 32'd1);
`ifdef CONV_SEQ_CTRL_PERF_EN
    check("stall_cnt_cleared", stall_cnt, 32'd0);
    check("frame_cnt_cleared", 32'(frame_cnt), 32'd0);
`endif
    repeat (60) @(posedge clk);
    #1;
    check("no_y_without_load", 32'(ycnt[0]), 32'(97 + 39));
    check("no_valid_without_load", 32'(m_valid_y), 32'd0);

    // Frame 3: clean frame after the abort
    load_frame_big();
    wait_y(0, 97 + 39 + 97, 97 * 40);
    check("load_after_frame3", 32'(s_ready_x), 32'd1);
    check("queue_empty_frame3", 32'(bq0.size()), 32'd0);
`ifdef CONV_SEQ_CTRL_PERF_EN
    check("frame_cnt_after_abort", 32'(frame_cnt), 32'd1);
`endif

    // Small instance: 3 frames with random valid/ready
    reset_s = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int b = 0; b <= N1 - M1; b++) bq1.push_back(b);
    n = 0;
    while (ycnt[1] < 18 && n < 3000) begin
      @(posedge clk);
      #1;
      s_valid_s = 1'($urandom_range(0, 1));
      m_ready_s = 1'($urandom_range(0, 1));
      n++;
    end
    s_valid_s = 1'b0;
    m_ready_s = 1'b0;
    check("small_y_count", 32'(ycnt[1]), 32'd18);
    check("small_writes", 32'(wcnt[1]), 32'd24);
    check("small_queue_empty", 32'(bq1.size()), 32'd0);
    check("small_back_to_load", 32'(s_ready_s), 32'd1);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
